nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter FREQ_CTRL_WORD_LEN, default 8, giving the width of the frequency word (delta_phi) driven to the NCO.
REQ-002 SHALL have parameter DWELL_BITS, default 12, giving the width of the per-step dwell count.
REQ-003 SHALL have parameter STEP_BITS, default 6, giving the width of the step count and step index.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: terminate the sweep immediately.
REQ-008 SHALL have port f_start, input, FREQ_CTRL_WORD_LEN bits: first frequency word.
REQ-009 SHALL have port f_step, input, FREQ_CTRL_WORD_LEN bits: two's-complement increment per step.
REQ-010 SHALL have port n_steps, input, STEP_BITS bits: number of increments (the sweep holds n_steps+1 frequencies).
REQ-011 SHALL have port dwell, input, DWELL_BITS bits: each frequency is held for dwell+1 cycles.
REQ-012 SHALL have port loop_en, input, 1 bit: restart the sweep from f_start instead of finishing.
REQ-013 SHALL have port delta_phi, output, FREQ_CTRL_WORD_LEN bits: registered frequency word to the NCO.
REQ-014 SHALL have port nco_ena, output, 1 bit: registered enable to the NCO.
REQ-015 SHALL have port busy, output, 1 bit: high while in SWEEP.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at normal completion.
REQ-017 SHALL have port step_idx, output, STEP_BITS bits: index of the frequency currently driven.

Function
REQ-018 SHALL implement an FSM with exactly three states: IDLE, SWEEP, DONE.
REQ-019 SHALL, in IDLE with start=1 and abort=0, latch f_start, f_step, n_steps, dwell and loop_en into internal registers, and on the next cycle present SWEEP, delta_phi=f_start, step_idx=0, nco_ena=1, busy=1 (latency: one cycle).
REQ-020 SHALL ignore input changes after latching; only the latched copies govern the sweep in progress.
REQ-021 SHALL ignore start while in SWEEP or DONE.
REQ-022 SHALL, in SWEEP, increment the dwell counter each cycle and, when it equals the latched dwell, clear it and advance.
REQ-023 SHALL advance as follows when step_idx < n_steps: delta_phi <= delta_phi + f_step, modulo 2^FREQ_CTRL_WORD_LEN (wrap, no saturation), and step_idx <= step_idx+1.
REQ-024 SHALL, when advancing with step_idx == n_steps and loop_en latched 1, set delta_phi=f_start and step_idx=0 and remain in SWEEP, without a done pulse.
REQ-025 SHALL, when advancing with step_idx == n_steps and loop_en latched 0, go to DONE.
REQ-026 SHALL hold a non-looping sweep in SWEEP for exactly (n_steps+1)*(dwell+1) cycles.
REQ-027 SHALL, in DONE, assert done=1, nco_ena=0 and busy=0 for exactly one cycle, hold delta_phi at its last value, then return to IDLE.
REQ-028 SHALL, when abort=1 in any state, move to IDLE on the next cycle with nco_ena=0, busy=0, done=0 and delta_phi held; abort has priority over start and over a step advance in the same cycle.
REQ-029 SHALL keep nco_ena=0 and busy=0 in IDLE.
REQ-030 SHALL, with n_steps=0 and dwell=0, produce one SWEEP cycle at f_start followed by DONE.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force state=IDLE, and delta_phi, step_idx, the dwell counter and all latched registers to 0, and nco_ena, busy and done to 0.
REQ-032 SHALL, on reset asserted mid-sweep, abandon the sweep with no done pulse; the first start after rst_n rises behaves per REQ-019.

Structure
REQ-033 SHALL place the state encoding (IDLE, SWEEP, DONE) and the default width constants in a shared package nco_ctrl_pkg.
REQ-034 SHALL implement the dwell counter, with its terminal-count flag, as one sub-module dwell_timer; all other logic SHALL be in nco_sweep_ctrl.

Verification
REQ-035 SHALL cover: f_start=0x10, f_step=0x04, n_steps=3, dwell=2, loop_en=0 -> delta_phi 0x10,0x14,0x18,0x1C each held 3 cycles, busy for 12 cycles, then one done pulse.
REQ-036 SHALL cover: f_start=0xF8, f_step=0x08, n_steps=2, dwell=0 -> delta_phi 0xF8,0x00,0x08 (wrap), then done.
REQ-037 SHALL cover: f_step=0xFC (-4), f_start=0x08, n_steps=2, dwell=1, loop_en=1 -> repeating 0x08,0x04,0x00 with 2 cycles each, never done, busy constantly 1.
REQ-038 SHALL cover: abort asserted at step_idx=1 -> IDLE next cycle, nco_ena=0, no done; start and abort together in IDLE -> remains IDLE.
REQ-039 SHALL cover: rst_n pulsed low mid-sweep -> all outputs 0 immediately, without waiting for a clock edge; start repeated mid-sweep -> ignored.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared state encoding and default widths for the NCO sweep controller.
package nco_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int FREQ_W  = 8;
    localparam int DWELL_W = 12;
    localparam int STEP_W  = 6;

endpackage

// File: rtl/dwell_timer.sv
// Per-step dwell counter: counts 0..limit, wraps to 0 on terminal count.
module dwell_timer
    import nco_ctrl_pkg::*;
#(
    parameter int DWELL_BITS = DWELL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DWELL_BITS-1:0] limit,
    output logic                  tc
);

    logic [DWELL_BITS-1:0] count;

    assign tc = (count == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep sequencer: steps an NCO frequency word from a latched
// start value in fixed increments, holding each word for a dwell period.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int FREQ_CTRL_WORD_LEN = FREQ_W,
    parameter int DWELL_BITS         = DWELL_W,
    parameter int STEP_BITS          = STEP_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [FREQ_CTRL_WORD_LEN-1:0] f_start,
    input  logic [FREQ_CTRL_WORD_LEN-1:0] f_step,
    input  logic [STEP_BITS-1:0]          n_steps,
    input  logic [DWELL_BITS-1:0]         dwell,
    input  logic                          loop_en,
    output logic [FREQ_CTRL_WORD_LEN-1:0] delta_phi,
    output logic                          nco_ena,
    output logic                          busy,
    output logic                          done,
    output logic [STEP_BITS-1:0]          step_idx
);

    state_t state;

    logic [FREQ_CTRL_WORD_LEN-1:0] f_start_q;
    logic [FREQ_CTRL_WORD_LEN-1:0] f_step_q;
    logic [STEP_BITS-1:0]          n_steps_q;
    logic [DWELL_BITS-1:0]         dwell_q;
    logic                          loop_q;

    logic tc;
    logic timer_clear;
    logic advance;
    logic last_step;

    // Counter only runs while sweeping; abort restarts it from zero.
    assign timer_clear = (state != SWEEP) || abort;
    assign advance     = (state == SWEEP) && tc;
    assign last_step   = (step_idx == n_steps_q);

    dwell_timer #(
        .DWELL_BITS(DWELL_BITS)
    ) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(timer_clear),
        .limit(dwell_q),
        .tc   (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            f_start_q <= '0;
            f_step_q  <= '0;
            n_steps_q <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
            delta_phi <= '0;
            step_idx  <= '0;
            nco_ena   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            nco_ena <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        f_start_q <= f_start;
                        f_step_q  <= f_step;
                        n_steps_q <= n_steps;
                        dwell_q   <= dwell;
                        loop_q    <= loop_en;
                        delta_phi <= f_start;
                        step_idx  <= '0;
                        nco_ena   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (advance) begin
                        unique case (1'b1)
                            !last_step: begin
                                delta_phi <= delta_phi + f_step_q;
                                step_idx  <= step_idx + 1'b1;
                            end
                            last_step && loop_q: begin
                                delta_phi <= f_start_q;
                                step_idx  <= '0;
                            end
                            last_step && !loop_q: begin
                                nco_ena <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state   <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    nco_ena <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: table of sweep configurations with expected
// frequency lists, expanded into a per-cycle scoreboard queue.
module tb_nco_sweep_ctrl;

    localparam int FW = 8;
    localparam int DW = 12;
    localparam int SW = 6;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_step;
    logic [SW-1:0] n_steps;
    logic [DW-1:0] dwell;
    logic          loop_en;
    logic [FW-1:0] delta_phi;
    logic          nco_ena;
    logic          busy;
    logic          done;
    logic [SW-1:0] step_idx;

    nco_sweep_ctrl #(
        .FREQ_CTRL_WORD_LEN(FW),
        .DWELL_BITS        (DW),
        .STEP_BITS         (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .f_start  (f_start),
        .f_step   (f_step),
        .n_steps  (n_steps),
        .dwell    (dwell),
        .loop_en  (loop_en),
        .delta_phi(delta_phi),
        .nco_ena  (nco_ena),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string               name;
        logic [FW-1:0]       fs;
        logic [FW-1:0]       fst;
        logic [SW-1:0]       ns;
        logic [DW-1:0]       dw;
        logic                lp;
        int                  nfreq;
        logic [3:0][FW-1:0]  freqs;
        int                  abort_after;
        bit                  garble;
    } vec_t;

    typedef struct {
        logic          busy;
        logic          ena;
        logic          done;
        logic [FW-1:0] dphi;
        logic [SW-1:0] idx;
        bit            chk_idx;
        bit            abort_in;
        bit            start_in;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(string nm, logic [FW-1:0] fs,
                                logic [FW-1:0] fst, logic [SW-1:0] ns,
                                logic [DW-1:0] dw, logic lp, int nf,
                                logic [FW-1:0] q0, logic [FW-1:0] q1,
                                logic [FW-1:0] q2, logic [FW-1:0] q3,
                                int ab, bit gb);
        vec_t v;
        v.name = nm;
        v.fs = fs;
        v.fst = fst;
        v.ns = ns;
        v.dw = dw;
        v.lp = lp;
        v.nfreq = nf;
        v.freqs[0] = q0;
        v.freqs[1] = q1;
        v.freqs[2] = q2;
        v.freqs[3] = q3;
        v.abort_after = ab;
        v.garble = gb;
        return v;
    endfunction

    task automatic push(logic b, logic e, logic d, logic [FW-1:0] ph,
                        logic [SW-1:0] ix, bit ci, bit ab, bit st);
        exp_t x;
        x.busy = b;
        x.ena = e;
        x.done = d;
        x.dphi = ph;
        x.idx = ix;
        x.chk_idx = ci;
        x.abort_in = ab;
        x.start_in = st;
        exp_q.push_back(x);
    endtask

    // Expand one table row into the expected cycle-by-cycle outputs.
    task automatic build(vec_t v);
        int per;
        int k;
        int fi;
        bit fin;
        logic [FW-1:0] held;
        per = int'(v.dw) + 1;
        k = 0;
        fin = 0;
        while (!fin) begin
            if (v.abort_after >= 0 && k == v.abort_after) begin
                held = v.freqs[((k - 1) / per) % v.nfreq];
                push(0, 0, 0, held, '0, 0, 1, v.garble);
                push(0, 0, 0, held, '0, 0, 0, 0);
                fin = 1;
            end else if (!v.lp && k == v.nfreq * per) begin
                held = v.freqs[v.nfreq - 1];
                push(0, 0, 1, held, '0, 0, 0, v.garble);
                push(0, 0, 0, held, '0, 0, 0, v.garble);
                fin = 1;
            end else begin
                fi = (k / per) % v.nfreq;
                push(1, 1, 0, v.freqs[fi], SW'(fi), 1, 0,
                     (k == 0) ? 1'b1 : v.garble);
                k++;
            end
        end
    endtask

    task automatic compare(string nm, int cyc, exp_t e);
        bit ok;
        ok = (busy === e.busy) && (nco_ena === e.ena) &&
             (done === e.done) && (delta_phi === e.dphi) &&
             (!e.chk_idx || step_idx === e.idx);
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc%0d: got busy=%b ena=%b done=%b dphi=%h idx=%0d, need busy=%b ena=%b done=%b dphi=%h idx=%0d",
                     nm, cyc, busy, nco_ena, done, delta_phi, step_idx,
                     e.busy, e.ena, e.done, e.dphi, e.idx);
        end
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] need);
        n_checks++;
        if (got === need) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h need %h", nm, got, need);
        end
    endtask

    task automatic drive_cfg(vec_t v);
        f_start = v.fs;
        f_step  = v.fst;
        n_steps = v.ns;
        dwell   = v.dw;
        loop_en = v.lp;
    endtask

    task automatic scramble();
        f_start = FW'($urandom);
        f_step  = FW'($urandom);
        n_steps = SW'($urandom);
        dwell   = DW'($urandom);
        loop_en = 1'($urandom);
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic run(vec_t v);
        exp_t e;
        int cyc;
        drive_cfg(v);
        build(v);
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            start = e.start_in;
            abort = e.abort_in;
            @(posedge clk);
            #1;
            compare(v.name, cyc, e);
            scramble();
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic chk_idle_zero(string nm);
        chk({nm, ".busy"}, 32'(busy), 32'd0);
        chk({nm, ".ena"}, 32'(nco_ena), 32'd0);
        chk({nm, ".done"}, 32'(done), 32'd0);
        chk({nm, ".dphi"}, 32'(delta_phi), 32'd0);
        chk({nm, ".idx"}, 32'(step_idx), 32'd0);
    endtask

    initial begin
        vecs[0] = mk("ramp", 8'h10, 8'h04, 6'd3, 12'd2, 1'b0, 4,
                     8'h10, 8'h14, 8'h18, 8'h1C, -1, 0);
        vecs[1] = mk("wrap", 8'hF8, 8'h08, 6'd2, 12'd0, 1'b0, 3,
                     8'hF8, 8'h00, 8'h08, 8'h00, -1, 1);
        vecs[2] = mk("loop", 8'h08, 8'hFC, 6'd2, 12'd1, 1'b1, 3,
                     8'h08, 8'h04, 8'h00, 8'h00, 18, 1);
        vecs[3] = mk("single", 8'h55, 8'h33, 6'd0, 12'd0, 1'b0, 1,
                     8'h55, 8'h00, 8'h00, 8'h00, -1, 0);
        vecs[4] = mk("dwell4", 8'h7F, 8'h01, 6'd1, 12'd3, 1'b0, 2,
                     8'h7F, 8'h80, 8'h00, 8'h00, -1, 1);
        vecs[5] = mk("abort1", 8'h10, 8'h04, 6'd3, 12'd2, 1'b0, 4,
                     8'h10, 8'h14, 8'h18, 8'h1C, 4, 1);

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        f_start = '0;
        f_step = '0;
        n_steps = '0;
        dwell = '0;
        loop_en = 1'b0;
        #1;
        chk_idle_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run(vecs[i]);
        end

        drive_cfg(vecs[0]);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort.busy", 32'(busy), 32'd0);
        chk("start_abort.ena", 32'(nco_ena), 32'd0);
        @(posedge clk);
        #1;
        chk("start_abort.still_idle", 32'(busy), 32'd0);
        chk("start_abort.no_done", 32'(done), 32'd0);

        drive_cfg(vecs[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset.no_done", 32'(done), 32'd0);
        chk("post_reset.busy", 32'(busy), 32'd0);
        run(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
